level_sensor_conditioner: RTL and testbench
===========================================

Name: level_sensor_conditioner

Overview:
Input-conditioning stage directly upstream of the tank level/pump controller (`counter` instance) in the SmartBing top level. It takes three raw pad inputs: supply/start switch Su, high-level probe Lh and low-level probe Ll. For each it provides synchronisation, debouncing and edge pulses. It also flags the physically impossible "high wet, low dry" probe combination as a sticky sensor fault, which the controller uses to drive its alarm.

Parameters:
DEB_BITS, 8, width of each per-channel debounce counter.
DEB_COUNT, 200, consecutive enabled samples a changed input must hold before the clean output follows; legal range 1 .. 2^DEB_BITS-1.
FAULT_CYCLES, 16, consecutive enabled samples of the impossible combination before sensor_fault sets; legal range 1 .. 255 (8-bit fault counter).

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
en  input  1  sample strobe; debounce and fault counters advance only when high
su_raw  input  1  raw supply/start switch
lh_raw  input  1  raw high-level probe (1 = wet)
ll_raw  input  1  raw low-level probe (1 = wet)
fault_clr  input  1  synchronous clear of sticky fault
su_clean  output  1  debounced Su
lh_clean  output  1  debounced Lh
ll_clean  output  1  debounced Ll
su_rise  output  1  one-cycle pulse on su_clean 0->1
lh_rise  output  1  one-cycle pulse on lh_clean 0->1 (tank reached high)
ll_fall  output  1  one-cycle pulse on ll_clean 1->0 (tank dropped below low)
sensor_fault  output  1  sticky implausible-probe flag

Behaviour:
- Clocking and reset: single clock domain with asynchronous active-low reset rst_n.
- Reset state: all sync flops, counters, clean outputs, pulses and sensor_fault are 0.
- Synchroniser: two-flop synchroniser per raw input, with no logic between the flops. sync_x is the second-flop output.
- Debounce, per channel:
  - If sync_x == clean_x, cnt_x <= 0.
  - Else if en=1 and cnt_x == DEB_COUNT-1, then clean_x <= sync_x and cnt_x <= 0.
  - Else if en=1, cnt_x <= cnt_x+1.
  - Else (en=0), cnt_x holds.
- Debounce boundary conditions:
  - A glitch shorter than DEB_COUNT enabled samples never reaches clean_x.
  - Any sample with sync_x == clean_x restarts the count.
  - The counter never wraps, because it is bounded by DEB_COUNT-1.
- Latency: with en tied high, a clean step on a raw input appears on clean_x exactly DEB_COUNT+2 cycles later.
- Edge pulses: registered and high for exactly the one cycle in which clean_x first shows its new value. su_rise and lh_rise fire on 0->1; ll_fall fires on 1->0. No pulse is generated at reset release.
- Fault detection:
  - The condition is lh_clean=1 && ll_clean=0.
  - 8-bit fault counter fcnt: cleared whenever the condition is false.
  - While the condition is true and en=1, fcnt increments, saturating at FAULT_CYCLES.
  - When the increment takes fcnt to FAULT_CYCLES, sensor_fault <= 1 on that same edge.
- Fault stickiness:
  - sensor_fault stays 1 after the condition disappears, until fault_clr or reset.
  - fault_clr=1 forces sensor_fault <= 0 and fcnt <= 0, with priority over a set in the same cycle.
  - If the condition persists after a clear, fault re-asserts FAULT_CYCLES enabled samples later.
- Simultaneous changes: channels are independent. Several clean outputs and pulses may change in the same cycle.
- Reset mid-operation: asynchronous return to the reset state, with all partial counts lost.

Test Plan:
All directed tests use DEB_COUNT=4 and FAULT_CYCLES=3.
1. Reset: hold rst_n=0 with all raw inputs at 1, then release with en=1 -> all clean outputs and pulses stay 0 for 5 cycles, then su_clean, lh_clean and ll_clean go to 1 together in cycle 6. su_rise and lh_rise pulse once; ll_fall stays 0.
2. Debounce latency and glitch rejection, en=1:
   - ll_raw 0->1 held -> ll_clean=1 exactly 6 cycles later.
   - ll_raw pulses high for 3 cycles -> ll_clean, ll_fall and lh_rise unchanged throughout.
3. en gating: en toggles 1,0,1,0... while su_raw steps to 1 -> su_clean changes 2 sync cycles plus 4 enabled samples after the step, about 10 cycles. The count holds during en=0 cycles.
4. Edge pulses:
   - ll_clean falls 1->0 -> ll_fall is high for exactly 1 cycle.
   - lh_clean rises -> lh_rise is high for exactly 1 cycle.
   - Both channels stepped together -> both pulses occur in the same cycle.
5. Fault set and stickiness:
   - Debounce lh=1, ll=0 with en=1 -> sensor_fault=1 on the 3rd enabled cycle of the condition.
   - Remove the condition -> sensor_fault stays 1.
   - Pulse fault_clr -> sensor_fault=0 the next cycle.
6. Clear vs set collision: with the condition present, assert fault_clr in the cycle fcnt would reach 3 -> sensor_fault stays 0, then sets 3 enabled cycles later. Assert rst_n=0 mid-debounce -> all outputs 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/level_sensor_conditioner.sv
// Conditions the Su/Lh/Ll pad inputs: two-flop sync, per-channel debounce, edge pulses,
// and a sticky fault flag for the impossible "high probe wet, low probe dry" state.
module level_sensor_conditioner #(
    parameter int DEB_BITS     = 8,
    parameter int DEB_COUNT    = 200,
    parameter int FAULT_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic su_raw,
    input  logic lh_raw,
    input  logic ll_raw,
    input  logic fault_clr,
    output logic su_clean,
    output logic lh_clean,
    output logic ll_clean,
    output logic su_rise,
    output logic lh_rise,
    output logic ll_fall,
    output logic sensor_fault
);

    localparam logic [DEB_BITS-1:0] DEB_LAST = DEB_BITS'(DEB_COUNT - 1);
    localparam logic [7:0]          FLT_MAX  = 8'(FAULT_CYCLES);

    // Channel index: 0 = Su, 1 = Lh, 2 = Ll.
    logic [2:0]          sync1;
    logic [2:0]          sync2;
    logic [2:0]          clean;
    logic [DEB_BITS-1:0] cnt [3];
    logic [2:0]          flip;
    logic [7:0]          fcnt;
    logic                fault_cond;

    always_comb begin
        flip = 3'b000;
        for (int i = 0; i < 3; i++) begin
            flip[i] = (sync2[i] != clean[i]) && en && (cnt[i] == DEB_LAST);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
            clean <= 3'b000;
            for (int i = 0; i < 3; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            sync1 <= {ll_raw, lh_raw, su_raw};
            sync2 <= sync1;
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == clean[i]) begin
                    cnt[i] <= '0;
                end else if (flip[i]) begin
                    clean[i] <= sync2[i];
                    cnt[i]   <= '0;
                end else if (en) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end
            end
        end
    end

    // Pulses are registered on the same edge that updates clean, so they align with the new value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            su_rise <= 1'b0;
            lh_rise <= 1'b0;
            ll_fall <= 1'b0;
        end else begin
            su_rise <= flip[0] & sync2[0];
            lh_rise <= flip[1] & sync2[1];
            ll_fall <= flip[2] & ~sync2[2];
        end
    end

    assign fault_cond = clean[1] & ~clean[2];

    // Clear wins over a set landing in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fcnt         <= 8'd0;
            sensor_fault <= 1'b0;
        end else if (fault_clr) begin
            fcnt         <= 8'd0;
            sensor_fault <= 1'b0;
        end else if (!fault_cond) begin
            fcnt <= 8'd0;
        end else if (en && (fcnt != FLT_MAX)) begin
            fcnt <= fcnt + 8'd1;
            if (fcnt + 8'd1 == FLT_MAX) begin
                sensor_fault <= 1'b1;
            end
        end
    end

    assign su_clean = clean[0];
    assign lh_clean = clean[1];
    assign ll_clean = clean[2];

endmodule

// File: tb/tb_level_sensor_conditioner.sv
// Bench for level_sensor_conditioner: directed plan steps, then random raw/en/clear traffic
// compared every cycle against a delay-line and streak-count model of the conditioner.
module tb_level_sensor_conditioner;

    localparam int DEB = 4;
    localparam int FC  = 3;

    logic clk = 1'b0;
    logic rst_n, en, su_raw, lh_raw, ll_raw, fault_clr;
    logic su_clean, lh_clean, ll_clean, su_rise, lh_rise, ll_fall, sensor_fault;

    int checks = 0;
    int errors = 0;

    // Model state: raw history (two-cycle delay), settled levels, streaks, fault flag.
    logic [2:0] raw_hist [$];
    logic [2:0] m_clean;
    logic [2:0] m_pulse_up;
    logic [2:0] m_pulse_dn;
    int         m_streak [3];
    int         m_fstreak;
    logic       m_fault;

    always #5 clk = ~clk;

    level_sensor_conditioner #(
        .DEB_BITS    (8),
        .DEB_COUNT   (DEB),
        .FAULT_CYCLES(FC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .su_raw      (su_raw),
        .lh_raw      (lh_raw),
        .ll_raw      (ll_raw),
        .fault_clr   (fault_clr),
        .su_clean    (su_clean),
        .lh_clean    (lh_clean),
        .ll_clean    (ll_clean),
        .su_rise     (su_rise),
        .lh_rise     (lh_rise),
        .ll_fall     (ll_fall),
        .sensor_fault(sensor_fault)
    );

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        raw_hist   = {3'b000, 3'b000};
        m_clean    = 3'b000;
        m_pulse_up = 3'b000;
        m_pulse_dn = 3'b000;
        m_fstreak  = 0;
        m_fault    = 1'b0;
        for (int i = 0; i < 3; i++) m_streak[i] = 0;
    endtask

    task automatic check_all();
        chk("su_clean", su_clean, m_clean[0]);
        chk("lh_clean", lh_clean, m_clean[1]);
        chk("ll_clean", ll_clean, m_clean[2]);
        chk("su_rise", su_rise, m_pulse_up[0]);
        chk("lh_rise", lh_rise, m_pulse_up[1]);
        chk("ll_fall", ll_fall, m_pulse_dn[2]);
        chk("sensor_fault", sensor_fault, m_fault);
    endtask

    // One clock: the model consumes the inputs held across the edge, then outputs are compared.
    task automatic tick();
        logic [2:0] seen;
        logic       impossible;
        @(posedge clk);
        seen       = raw_hist[0];
        impossible = m_clean[1] && !m_clean[2];
        m_pulse_up = 3'b000;
        m_pulse_dn = 3'b000;
        for (int i = 0; i < 3; i++) begin
            if (seen[i] == m_clean[i]) begin
                m_streak[i] = 0;
            end else if (en) begin
                m_streak[i]++;
                if (m_streak[i] == DEB) begin
                    m_clean[i]    = seen[i];
                    m_pulse_up[i] = seen[i];
                    m_pulse_dn[i] = !seen[i];
                    m_streak[i]   = 0;
                end
            end
        end
        if (fault_clr) begin
            m_fstreak = 0;
            m_fault   = 1'b0;
        end else if (!impossible) begin
            m_fstreak = 0;
        end else if (en && m_fstreak < FC) begin
            m_fstreak++;
            if (m_fstreak == FC) m_fault = 1'b1;
        end
        void'(raw_hist.pop_front());
        raw_hist.push_back({ll_raw, lh_raw, su_raw});
        #1;
        check_all();
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        int         first;
        int         cnt_a, cnt_b, cnt_c;
        logic       glitch_seen;
        int         edge_p;

        // 1. Reset with raw inputs high, release with en=1.
        rst_n = 1'b0; en = 1'b0; fault_clr = 1'b0;
        su_raw = 1'b1; lh_raw = 1'b1; ll_raw = 1'b1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        rst_n = 1'b1; en = 1'b1;
        first = -1; cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int c = 1; c <= 10; c++) begin
            tick();
            if (first < 0 && su_clean && lh_clean && ll_clean) first = c;
            cnt_a += int'(su_rise); cnt_b += int'(lh_rise); cnt_c += int'(ll_fall);
        end
        chk_int("reset_release_latency", first, 6);
        chk_int("reset_su_rise_count", cnt_a, 1);
        chk_int("reset_lh_rise_count", cnt_b, 1);
        chk_int("reset_ll_fall_count", cnt_c, 0);

        // 2. Latency and glitch rejection on Ll.
        su_raw = 1'b0; lh_raw = 1'b0; ll_raw = 1'b0;
        settle(8);
        ll_raw = 1'b1;
        first = -1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            if (first < 0 && ll_clean) first = c;
        end
        chk_int("ll_step_latency", first, 6);
        ll_raw = 1'b0;
        settle(8);
        glitch_seen = 1'b0;
        ll_raw = 1'b1;
        settle(3);
        ll_raw = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            glitch_seen |= ll_clean | ll_fall | lh_rise;
        end
        chk("glitch_rejected", glitch_seen, 1'b0);

        // 3. en toggling while Su steps high: enabled samples land on odd cycles.
        su_raw = 1'b1;
        first = -1;
        for (int c = 1; c <= 16; c++) begin
            en = c[0];
            tick();
            if (first < 0 && su_clean) first = c;
        end
        chk_int("en_gated_latency", first, 9);
        en = 1'b1;

        // 4. Edge pulses: Ll fall, then Lh rise and Ll fall stepped together.
        ll_raw = 1'b1;
        settle(8);
        ll_raw = 1'b0;
        cnt_c = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            cnt_c += int'(ll_fall);
        end
        chk_int("ll_fall_width", cnt_c, 1);
        ll_raw = 1'b1;
        settle(8);
        lh_raw = 1'b1; ll_raw = 1'b0;
        cnt_a = 0; cnt_c = 0; edge_p = -1; first = -1;
        for (int c = 1; c <= 14; c++) begin
            tick();
            cnt_a += int'(lh_rise);
            cnt_c += int'(lh_rise && ll_fall);
            if (edge_p < 0 && lh_rise) edge_p = c;
            if (first < 0 && sensor_fault) first = c;
        end
        chk_int("lh_rise_width", cnt_a, 1);
        chk_int("both_pulses_same_cycle", cnt_c, 1);

        // 5. Fault sets on the 3rd enabled cycle of the condition, sticks, clears.
        chk_int("fault_set_delay", first - edge_p, FC);
        ll_raw = 1'b1;
        settle(8);
        chk("fault_sticky", sensor_fault, 1'b1);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("fault_cleared", sensor_fault, 1'b0);

        // 6. Clear colliding with set, then re-set three enabled cycles later.
        ll_raw = 1'b0;
        edge_p = -1;
        for (int c = 0; c < 10 && edge_p < 0; c++) begin
            tick();
            if (ll_fall) edge_p = c;
        end
        chk("collision_setup", edge_p >= 0, 1'b1);
        settle(2);
        fault_clr = 1'b1;
        tick();
        fault_clr = 1'b0;
        chk("clear_beats_set", sensor_fault, 1'b0);
        settle(2);
        chk("fault_not_yet", sensor_fault, 1'b0);
        tick();
        chk("fault_reasserted", sensor_fault, 1'b1);

        // Asynchronous reset mid-debounce, between clock edges.
        su_raw = 1'b0;
        settle(4);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 5) == 0) su_raw = ~su_raw;
            if ($urandom_range(0, 5) == 0) lh_raw = ~lh_raw;
            if ($urandom_range(0, 5) == 0) ll_raw = ~ll_raw;
            en        = ($urandom_range(0, 3) != 0);
            fault_clr = ($urandom_range(0, 40) == 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
